// File: rtl/msdap_pkg.sv
// Shared types and default sizing for the MSDAP host-side stream transmitter.
package msdap_pkg;

    // Load sequence of the chip input port: Rj words, then coefficients, then data.
    typedef enum logic [1:0] {
        PH_RJ    = 2'd0,
        PH_COEFF = 2'd1,
        PH_DATA  = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StShift   = 2'd1,
        StRstSlot = 2'd2
    } tx_state_e;

    localparam int unsigned DEFAULT_WORD_W      = 16;
    localparam int unsigned DEFAULT_RJ_COUNT    = 16;
    localparam int unsigned DEFAULT_COEFF_COUNT = 512;

endpackage

// File: rtl/msdap_stream_tx_if.sv
// Word handshake from the upstream source plus the serial lines to the chip.
interface msdap_stream_tx_if #(
    parameter int unsigned WORD_W = msdap_pkg::DEFAULT_WORD_W
);
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_l;
    logic [WORD_W-1:0] word_r;
    logic              in_ready;
    logic              frame;
    logic              data_l;
    logic              data_r;
    logic              reset_n;

    // Transmitter side: consumes words, drives the serial lines.
    modport master (
        input  word_valid, word_l, word_r, in_ready,
        output word_ready, frame, data_l, data_r, reset_n
    );

    // Source/chip side.
    modport slave (
        output word_valid, word_l, word_r, in_ready,
        input  word_ready, frame, data_l, data_r, reset_n
    );
endinterface

// File: rtl/msdap_stream_tx_piso.sv
// Parallel-in serial-out shift register, MSB first; zeros shift in behind the word
// so the line idles low once a word has been fully sent.
module tx_piso #(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              start,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              dout
);
    logic [WORD_W-1:0] sr_q, sr_d;

    // Load has priority over shift so a back-to-back word replaces the last bit.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[WORD_W-2:0], 1'b0};
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[WORD_W-1];
endmodule

// File: rtl/msdap_stream_tx.sv
// MSDAP input-port transmitter: serialises stereo words with a frame pulse, tracks the
// Rj/coefficient/data load sequence and can insert a word-long chip reset slot.
module msdap_stream_tx
    import msdap_pkg::*;
#(
    parameter int unsigned WORD_W      = DEFAULT_WORD_W,
    parameter int unsigned RJ_COUNT    = DEFAULT_RJ_COUNT,
    parameter int unsigned COEFF_COUNT = DEFAULT_COEFF_COUNT
) (
    input  logic               clk,
    input  logic               start,
    msdap_stream_tx_if.master  bus,
    input  logic               host_reset,
    output logic [1:0]         phase,
    output logic               busy
);
    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned CNT_W = $clog2(COEFF_COUNT);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] RJ_LAST    = CNT_W'(RJ_COUNT - 1);
    localparam logic [CNT_W-1:0] COEFF_LAST = CNT_W'(COEFF_COUNT - 1);

    tx_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    phase_e           phase_q, phase_d;
    logic             frame_q, frame_d;
    logic             reset_n_q, reset_n_d;
    logic             busy_q, busy_d;

    logic boundary;
    logic rst_take;
    logic accept;
    logic shift_en;

    // Handshake: words are only taken at a word boundary; a pending reset slot wins.
    always_comb begin
        boundary       = (state_q == StIdle) || ((state_q == StShift) && (bit_cnt_q == BIT_LAST));
        rst_take       = boundary && host_reset && (phase_q == PH_DATA);
        bus.word_ready = boundary && bus.in_ready && !rst_take && !start;
        accept         = bus.word_ready && bus.word_valid;
    end

    // Next-state for the slot FSM, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        phase_d    = phase_q;
        frame_d    = 1'b0;
        shift_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StShift: begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                shift_en  = !accept;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = StIdle;
                end
            end
            StRstSlot: begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst_take) begin
            state_d   = StRstSlot;
            bit_cnt_d = '0;
        end else if (accept) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            frame_d   = 1'b1;
            unique case (phase_q)
                PH_RJ: begin
                    if (word_cnt_q == RJ_LAST) begin
                        phase_d    = PH_COEFF;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
                PH_COEFF: begin
                    if (word_cnt_q == COEFF_LAST) begin
                        phase_d    = PH_DATA;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        reset_n_d = (state_d != StRstSlot);
        busy_d    = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            phase_q    <= PH_RJ;
            frame_q    <= 1'b0;
            reset_n_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            phase_q    <= phase_d;
            frame_q    <= frame_d;
            reset_n_q  <= reset_n_d;
            busy_q     <= busy_d;
        end
    end

    tx_piso #(.WORD_W(WORD_W)) u_piso_l (
        .clk   (clk),
        .start (start),
        .load  (accept),
        .shift (shift_en),
        .din   (bus.word_l),
        .dout  (bus.data_l)
    );

    tx_piso #(.WORD_W(WORD_W)) u_piso_r (
        .clk   (clk),
        .start (start),
        .load  (accept),
        .shift (shift_en),
        .din   (bus.word_r),
        .dout  (bus.data_r)
    );

    assign bus.frame   = frame_q;
    assign bus.reset_n = reset_n_q;
    assign phase       = phase_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_msdap_stream_tx.sv
// Bench for msdap_stream_tx: a stream-level model predicts every output cycle from the
// sequence of accepted words and reset slots; directed tables and sequences cover corners.
`timescale 1ns/1ps
module tb_msdap_stream_tx;
    import msdap_pkg::*;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       start = 1'b0;
    logic       host_reset = 1'b0;
    logic [1:0] phase;
    logic       busy;

    msdap_stream_tx_if #(.WORD_W(W)) bus ();

    msdap_stream_tx #(.WORD_W(16), .RJ_COUNT(16), .COEFF_COUNT(512)) dut (
        .clk        (clk),
        .start      (start),
        .bus        (bus),
        .host_reset (host_reset),
        .phase      (phase),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One expected output cycle.
    typedef struct packed {
        logic frame;
        logic dl;
        logic dr;
        logic rn;
        logic bsy;
        logic rst;
    } cyc_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        msb_l;
        logic        msb_r;
        logic [15:0] ser_l;
        logic [15:0] ser_r;
    } vec_t;

    cyc_t q[$];
    cyc_t cur;
    int   n_acc;
    int   checks = 0;
    int   errors = 0;

    function automatic cyc_t idle_c();
        cyc_t c;
        c = '0;
        c.rn = 1'b1;
        return c;
    endfunction

    // Phase follows directly from how many words have been accepted since reset.
    function automatic int exp_phase();
        if (n_acc < 16) return 0;
        if (n_acc < 16 + 512) return 1;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: check current outputs, drive inputs, advance one cycle.
    task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r,
                        input logic ir, input logic hr, output logic acc);
        logic bnd, take_rst, exp_rdy;
        cyc_t c;
        chk("frame", bus.frame, cur.frame);
        chk("data_l", bus.data_l, cur.dl);
        chk("data_r", bus.data_r, cur.dr);
        chk("reset_n", bus.reset_n, cur.rn);
        chk("busy", busy, cur.bsy);
        chk("phase", phase, exp_phase());
        bus.word_valid = v;
        bus.word_l     = l;
        bus.word_r     = r;
        bus.in_ready   = ir;
        host_reset     = hr;
        #1;
        bnd      = (q.size() == 0) && !cur.rst;
        take_rst = bnd && hr && (exp_phase() == 2);
        exp_rdy  = bnd && ir && !take_rst;
        chk("word_ready", bus.word_ready, exp_rdy);
        acc = exp_rdy && v;
        @(posedge clk);
        if (take_rst) begin
            for (int i = 0; i < W; i++) begin
                c = '0;
                c.bsy = 1'b1;
                c.rst = 1'b1;
                q.push_back(c);
            end
        end else if (acc) begin
            for (int i = 0; i < W; i++) begin
                c = '0;
                c.frame = (i == 0);
                c.dl  = l[W-1-i];
                c.dr  = r[W-1-i];
                c.rn  = 1'b1;
                c.bsy = 1'b1;
                q.push_back(c);
            end
            n_acc++;
        end
        cur = (q.size() != 0) ? q.pop_front() : idle_c();
        @(negedge clk);
    endtask

    // Called at a falling edge; pulses start mid-cycle and checks the immediate effect.
    task automatic do_reset();
        bus.word_valid = 1'b0;
        bus.in_ready   = 1'b1;
        host_reset     = 1'b0;
        #2 start = 1'b1;
        #1;
        chk("rst_frame", bus.frame, 0);
        chk("rst_data_l", bus.data_l, 0);
        chk("rst_data_r", bus.data_r, 0);
        chk("rst_reset_n", bus.reset_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_phase", phase, 0);
        chk("rst_word_ready", bus.word_ready, 0);
        q.delete();
        cur   = idle_c();
        n_acc = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] l, input logic [15:0] r);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 64 && !acc; k++) step(1'b1, l, r, 1'b1, 1'b0, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance expected one within 64 cycles");
        end
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        logic        acc;
        logic [15:0] sl, sr;
        int          nfr, nlow, nbusy, bad, last;
        int          frames[$];

        tbl[0] = '{16'h8001, 16'h00FF, 1'b1, 1'b0, 16'h8001, 16'h00FF};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000};
        tbl[2] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'hA5A5, 16'h5A5A};
        tbl[3] = '{16'h0001, 16'h8000, 1'b0, 1'b1, 16'h0001, 16'h8000};

        bus.word_valid = 1'b0;
        bus.word_l     = '0;
        bus.word_r     = '0;
        bus.in_ready   = 1'b0;
        cur   = idle_c();
        n_acc = 0;
        @(negedge clk);
        do_reset();
        idle_cycles(2);

        // Table: single words, checked bit by bit after the acceptance edge.
        foreach (tbl[i]) begin
            send_word(tbl[i].l, tbl[i].r);
            chk("tbl_frame_first", bus.frame, 1);
            chk("tbl_msb_l", bus.data_l, tbl[i].msb_l);
            chk("tbl_msb_r", bus.data_r, tbl[i].msb_r);
            sl  = '0;
            sr  = '0;
            nfr = 0;
            for (int k = 0; k < W; k++) begin
                sl = {sl[14:0], bus.data_l};
                sr = {sr[14:0], bus.data_r};
                if (k > 0 && bus.frame) nfr++;
                step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
            end
            chk("tbl_ser_l", sl, tbl[i].ser_l);
            chk("tbl_ser_r", sr, tbl[i].ser_r);
            chk("tbl_extra_frame", nfr, 0);
            chk("tbl_gap_data_l", bus.data_l, 0);
        end

        // Continuous Rj load: 16 back-to-back words.
        do_reset();
        frames.delete();
        for (int c = 0; c < 300; c++) begin
            if (bus.frame) frames.push_back(c);
            step(n_acc < 16, 16'($urandom), 16'($urandom), 1'b1, 1'b0, acc);
            if (acc && n_acc == 16) chk("rj_phase_step", phase, 1);
        end
        chk("rj_frame_count", frames.size(), 16);
        bad = 0;
        for (int i = 1; i < frames.size(); i++) if (frames[i] - frames[i-1] != W) bad++;
        chk("rj_frame_gap_bad", bad, 0);

        // Full load sequence with random gating; host_reset sprinkled in all phases.
        for (int c = 0; c < 50000 && n_acc < 1528; c++) begin
            step(($urandom % 8) != 0, 16'($urandom), 16'($urandom), ($urandom % 8) != 0,
                 ($urandom % 64) == 0, acc);
            if (acc && n_acc == 528) chk("phase_data_entry", phase, 2);
        end
        chk("seq_budget", n_acc >= 1528, 1);
        chk("phase_final", phase, 2);

        // in_ready drops at bit 5: the word completes, nothing accepted until it returns.
        idle_cycles(20);
        send_word(16'h1234, 16'hFEDC);
        for (int k = 0; k < 5; k++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) nbusy++;
            step(1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b0, acc);
        end
        chk("ir_low_word_completes", nbusy, 11);
        send_word(16'h5555, 16'hAAAA);
        chk("ir_resume_frame", bus.frame, 1);
        chk("ir_resume_msb_r", bus.data_r, 1);

        // host_reset in DATA with a word waiting.
        idle_cycles(20);
        step(1'b1, 16'hC3C3, 16'h3C3C, 1'b1, 1'b1, acc);
        nlow = 0;
        nfr  = 0;
        for (int k = 0; k < 24; k++) begin
            if (!bus.reset_n) nlow++;
            if (!bus.reset_n && bus.frame) nfr++;
            step(1'b1, 16'hC3C3, 16'h3C3C, 1'b1, 1'b0, acc);
        end
        chk("hr_reset_n_low_cycles", nlow, 16);
        chk("hr_no_frame_in_slot", nfr, 0);
        chk("hr_phase_after", phase, 2);

        // start pulsed at bit 9 abandons the word and restarts the Rj count.
        idle_cycles(20);
        send_word(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 9; k++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
        do_reset();
        send_word(16'h0F0F, 16'hF0F0);
        chk("start_phase_rj", phase, 0);

        // host_reset in RJ phase is ignored.
        nlow = 0;
        nfr  = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.reset_n) nlow++;
            if (bus.frame) nfr++;
            step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, acc);
        end
        chk("hr_rj_no_slot", nlow, 0);
        chk("hr_rj_frames", nfr, 3);
        idle_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
